// File: rtl/img_arb_pkg.sv
// Shared types and constants for the image RAM arbiter and its read-return pipeline.
package img_arb_pkg;

    localparam int DEF_ADDR_W = 19;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VGA_RD = 2'd1,
        CPU_RD = 2'd2,
        CPU_WR = 2'd3
    } arb_state_e;

    typedef logic [1:0] tag_t;

    localparam tag_t TAG_NONE = 2'd0;
    localparam tag_t TAG_VGA  = 2'd1;
    localparam tag_t TAG_CPU  = 2'd2;

    // Which requester a slot's read data belongs to; writes and idle slots return nothing.
    function automatic tag_t state_tag(arb_state_e s);
        case (s)
            VGA_RD:  return TAG_VGA;
            CPU_RD:  return TAG_CPU;
            default: return TAG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/img_arb_rdpipe.sv
// Two-stage owner tag pipeline: steers synchronous RAM read data to the VGA or CPU port
// two edges after the slot was issued.
module img_arb_rdpipe
    import img_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        issue_tag,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_valid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid
);

    tag_t              tag0_q, tag0_d;
    tag_t              tag1_q, tag1_d;
    logic [DATA_W-1:0] vga_data_q, vga_data_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              vga_valid_q, vga_valid_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;

    // tag0 covers the cycle the address is on the bus, tag1 the cycle the RAM drives data.
    always_comb begin
        tag0_d       = issue_tag;
        tag1_d       = tag0_q;
        vga_valid_d  = (tag1_q == TAG_VGA);
        cpu_rvalid_d = (tag1_q == TAG_CPU);
        vga_data_d   = vga_valid_d  ? mem_rdata : vga_data_q;
        cpu_rdata_d  = cpu_rvalid_d ? mem_rdata : cpu_rdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag0_q       <= TAG_NONE;
            tag1_q       <= TAG_NONE;
            vga_data_q   <= '0;
            cpu_rdata_q  <= '0;
            vga_valid_q  <= 1'b0;
            cpu_rvalid_q <= 1'b0;
        end else begin
            tag0_q       <= tag0_d;
            tag1_q       <= tag1_d;
            vga_data_q   <= vga_data_d;
            cpu_rdata_q  <= cpu_rdata_d;
            vga_valid_q  <= vga_valid_d;
            cpu_rvalid_q <= cpu_rvalid_d;
        end
    end

    assign vga_data   = vga_data_q;
    assign vga_valid  = vga_valid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_rvalid = cpu_rvalid_q;

endmodule

// File: rtl/image_mem_arbiter.sv
// Single-port image RAM arbiter: VGA reads first, CPU in free slots with a starvation override.
// Build option IMGARB_WR_BLANK_EN restricts CPU writes to the VGA blanking interval.
module image_mem_arbiter
    import img_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    input  logic              vga_blank,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_valid,
    output logic              vga_miss,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       conflict_cnt
);

    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    arb_state_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [15:0]       conflict_q, conflict_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              cpu_gnt_q, cpu_gnt_d;
    logic              vga_miss_q, vga_miss_d;
    logic              wr_ok;
    logic              cpu_elig;
    logic              override;

`ifdef IMGARB_WR_BLANK_EN
    assign wr_ok = ~cpu_we | ~vga_blank;
`else
    assign wr_ok = 1'b1;
    logic unused_blank;
    assign unused_blank = vga_blank;
`endif

    // The grant strobe masks eligibility, forcing a one-cycle bubble after every CPU access.
    assign cpu_elig = cpu_req & ~cpu_gnt_q & wr_ok;
    assign override = cpu_elig & (wait_q == WAIT_MAX);

    // NOTE: every signal gets its default before any branch, so no path can infer a latch.
    always_comb begin
        state_d     = IDLE;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wait_d      = '0;
        conflict_d  = conflict_q;

        if (override) begin
            state_d = cpu_we ? CPU_WR : CPU_RD;
        end else if (vga_req) begin
            state_d = VGA_RD;
        end else if (cpu_elig) begin
            state_d = cpu_we ? CPU_WR : CPU_RD;
        end

        case (state_d)
            VGA_RD: mem_addr_d = vga_addr;
            CPU_RD: mem_addr_d = cpu_addr;
            CPU_WR: begin
                mem_addr_d  = cpu_addr;
                mem_wdata_d = cpu_wdata;
            end
            default: ;
        endcase

        cpu_gnt_d  = (state_d == CPU_RD) || (state_d == CPU_WR);
        mem_we_d   = (state_d == CPU_WR);
        vga_miss_d = override & vga_req;

        if (cpu_elig && !cpu_gnt_d) begin
            wait_d = wait_q + 1'b1;
            if (conflict_q != 16'hFFFF) begin
                conflict_d = conflict_q + 16'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wait_q      <= '0;
            conflict_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            cpu_gnt_q   <= 1'b0;
            vga_miss_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            conflict_q  <= conflict_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            cpu_gnt_q   <= cpu_gnt_d;
            vga_miss_q  <= vga_miss_d;
        end
    end

    img_arb_rdpipe #(
        .DATA_W (DATA_W)
    ) u_rdpipe (
        .clk        (clk),
        .reset      (reset),
        .issue_tag  (state_tag(state_d)),
        .mem_rdata  (mem_rdata),
        .vga_data   (vga_data),
        .vga_valid  (vga_valid),
        .cpu_rdata  (cpu_rdata),
        .cpu_rvalid (cpu_rvalid)
    );

    assign mem_addr     = mem_addr_q;
    assign mem_we       = mem_we_q;
    assign mem_wdata    = mem_wdata_q;
    assign cpu_gnt      = cpu_gnt_q;
    assign vga_miss     = vga_miss_q;
    assign conflict_cnt = conflict_q;

endmodule

// File: tb/tb_image_mem_arbiter.sv
// Self-checking bench for image_mem_arbiter: directed scenarios plus random traffic against
// a slot-level reference model with its own copy of the image RAM.
module tb_image_mem_arbiter;

    localparam int AW = 19;
    localparam int DW = 8;
    localparam int MW = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          vga_req, vga_blank, cpu_req, cpu_we;
    logic [AW-1:0] vga_addr, cpu_addr, mem_addr;
    logic [DW-1:0] cpu_wdata, vga_data, cpu_rdata, mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          vga_valid, vga_miss, cpu_gnt, cpu_rvalid, mem_we;
    logic [15:0]   conflict_cnt;

    image_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_blank(vga_blank),
        .vga_data(vga_data), .vga_valid(vga_valid), .vga_miss(vga_miss),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
    );

    always #20 clk = ~clk;

    function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
        if (a == 19'h00010) return 8'hA5;
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Synchronous read-first RAM with one cycle of read latency.
    logic [DW-1:0] ram [logic [AW-1:0]];
    always @(posedge clk) begin
        mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : init_val(mem_addr);
        if (mem_we) ram[mem_addr] = mem_wdata;
    end

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        bit            to_vga;
        logic [DW-1:0] data;
    } ret_t;

    ret_t          rq[$];
    logic [DW-1:0] ref_ram [logic [AW-1:0]];
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    bit            chk_en = 1'b1;
    bit            m_gnt, m_we, m_miss, m_vvalid, m_cvalid;
    int            m_wait, m_conf;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_vdata, m_cdata;

    function automatic logic [DW-1:0] ref_rd(logic [AW-1:0] a);
        return ref_ram.exists(a) ? ref_ram[a] : init_val(a);
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        rq.delete();
        m_gnt = 0; m_we = 0; m_miss = 0; m_vvalid = 0; m_cvalid = 0;
        m_wait = 0; m_conf = 0;
        m_addr = '0; m_wdata = '0; m_vdata = '0; m_cdata = '0;
    endtask

    // Applies the slot rules for one clock edge using the inputs held across that edge.
    task automatic model_edge();
        bit   wr_ok, elig, cpu_win, vga_win;
        ret_t r;
        cyc++;
        m_vvalid = 1'b0;
        m_cvalid = 1'b0;
        while (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            if (r.to_vga) begin m_vvalid = 1'b1; m_vdata = r.data; end
            else          begin m_cvalid = 1'b1; m_cdata = r.data; end
        end
        wr_ok = 1'b1;
`ifdef IMGARB_WR_BLANK_EN
        if (cpu_we && vga_blank) wr_ok = 1'b0;
`endif
        elig    = cpu_req && !m_gnt && wr_ok;
        cpu_win = elig && (m_wait == MW || !vga_req);
        vga_win = vga_req && !cpu_win;
        m_miss  = cpu_win && vga_req;
        m_gnt   = cpu_win;
        m_we    = cpu_win && cpu_we;
        if (vga_win) begin
            m_addr = vga_addr;
            rq.push_back('{cyc + 2, 1'b1, ref_rd(vga_addr)});
        end
        if (cpu_win) begin
            m_addr = cpu_addr;
            if (cpu_we) begin
                m_wdata = cpu_wdata;
                ref_ram[cpu_addr] = cpu_wdata;
            end else begin
                rq.push_back('{cyc + 2, 1'b0, ref_rd(cpu_addr)});
            end
        end
        if (elig && !cpu_win) begin
            m_wait++;
            if (m_conf < 65535) m_conf++;
        end else begin
            m_wait = 0;
        end
    endtask

    task automatic compare_all();
        check("vga_valid", vga_valid, m_vvalid);
        check("vga_data", vga_data, m_vdata);
        check("vga_miss", vga_miss, m_miss);
        check("cpu_gnt", cpu_gnt, m_gnt);
        check("cpu_rvalid", cpu_rvalid, m_cvalid);
        check("cpu_rdata", cpu_rdata, m_cdata);
        check("mem_we", mem_we, m_we);
        check("mem_addr", mem_addr, m_addr);
        check("mem_wdata", mem_wdata, m_wdata);
        check("conflict_cnt", conflict_cnt, m_conf);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
        if (chk_en) compare_all();
    endtask

    task automatic idle_inputs();
        vga_req = 0; cpu_req = 0; cpu_we = 0;
        vga_addr = '0; cpu_addr = '0; cpu_wdata = '0;
    endtask

    initial begin
        int gnt_at;
        int miss_n;

        // reset state
        reset = 1'b0;
        vga_blank = 1'b0;
        idle_inputs();
        #1;
        model_reset();
        compare_all();
        repeat (2) @(posedge clk);
        #5 reset = 1'b1;

        // CPU read alone
        cpu_req = 1; cpu_we = 0; cpu_addr = 19'h00010;
        tick();
        check("rd_gnt", cpu_gnt, 1'b1);
        check("rd_we", mem_we, 1'b0);
        cpu_req = 0;
        tick();
        tick();
        check("rd_rvalid", cpu_rvalid, 1'b1);
        check("rd_rdata", cpu_rdata, 8'hA5);
        repeat (2) tick();

        // VGA streaming with a pending write
        cpu_req = 1; cpu_we = 1; cpu_addr = 19'h00200; cpu_wdata = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            vga_req = 1; vga_addr = AW'(i + 32);
            tick();
            check("stream_no_gnt", cpu_gnt, 1'b0);
        end
        check("stream_conflict", conflict_cnt, 16'd8);
        vga_req = 0;
        tick();
        check("stream_gnt", cpu_gnt, 1'b1);
        check("stream_we", mem_we, 1'b1);
        check("stream_wdata", mem_wdata, 8'h3C);
        cpu_req = 0;
        tick();
        check("stream_we_off", mem_we, 1'b0);
        repeat (2) tick();

        // continuous VGA, pending read: starvation override
        gnt_at = 0;
        miss_n = 0;
        vga_req = 1; vga_addr = 19'h00040;
        cpu_req = 1; cpu_we = 0; cpu_addr = 19'h00200;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (cpu_gnt && gnt_at == 0) gnt_at = i;
            if (vga_miss) miss_n++;
            if (cpu_gnt) cpu_req = 0;
        end
        check("ovr_gnt_edge", gnt_at, 16);
        check("ovr_miss_count", miss_n, 1);
        check("ovr_conflict", conflict_cnt, 16'd23);
        tick();
        check("ovr_miss_once", vga_miss, 1'b0);
        vga_req = 0;
        tick();
        check("ovr_rvalid", cpu_rvalid, 1'b1);
        check("ovr_rdata", cpu_rdata, 8'h3C);
        repeat (2) tick();

        // write while VGA is in active video
        vga_blank = 1; cpu_req = 1; cpu_we = 1; cpu_addr = 19'h00300; cpu_wdata = 8'h77;
        tick();
`ifdef IMGARB_WR_BLANK_EN
        check("blank_no_gnt", cpu_gnt, 1'b0);
        tick();
        check("blank_no_gnt2", cpu_gnt, 1'b0);
        check("blank_conflict", conflict_cnt, 16'd23);
        vga_blank = 0;
        tick();
`endif
        check("blank_gnt", cpu_gnt, 1'b1);
        check("blank_we", mem_we, 1'b1);
        cpu_req = 0;
        tick();
        check("blank_we_off", mem_we, 1'b0);
        vga_blank = 0;
        tick();

        // reset one cycle after a VGA read is issued
        vga_req = 1; vga_addr = 19'h00055;
        tick();
        idle_inputs();
        tick();
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_no_vvalid", vga_valid, 1'b0);
        end
        #5 reset = 1'b1;
        vga_req = 1; vga_addr = 19'h00055;
        tick();
        vga_req = 0;
        tick();
        tick();
        check("post_rst_vvalid", vga_valid, 1'b1);
        check("post_rst_vdata", vga_data, init_val(19'h00055));

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            vga_req  = ($urandom_range(0, 9) < 6);
            vga_addr = AW'($urandom_range(0, 63));
            if ($urandom_range(0, 15) == 0) vga_blank = ~vga_blank;
            if ((cpu_req && cpu_gnt) || !cpu_req) begin
                cpu_req   = cpu_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0);
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = AW'($urandom_range(0, 63));
                cpu_wdata = DW'($urandom);
            end
            tick();
        end

        // conflict counter saturation
        vga_blank = 0; vga_req = 1; vga_addr = 19'h00001;
        cpu_req = 1; cpu_we = 0; cpu_addr = 19'h00002;
        chk_en = 1'b0;
        repeat (80000) tick();
        chk_en = 1'b1;
        tick();
        check("sat_conflict", conflict_cnt, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/image_mem_arbiter.md
# image_mem_arbiter

Single-port arbiter and sequencer for the shared image RAM, placed between the VGA pixel fetcher and the ImageFilter processor load/store path. VGA reads have priority and a fixed two-edge return latency. Processor reads and writes use a request/grant handshake and are served in free slots. A wait counter bounds processor starvation, and a saturating counter records contention for debug.

## Interface
- ADDR_W, 19, image RAM address width (640x480 bytes)
- DATA_W, 8, pixel width
- MAX_WAIT, 15, consecutive eligible-but-denied CPU cycles before CPU override
- clk  in  1  pixel clock (25 MHz domain)
- reset  in  1  asynchronous, active-low
- vga_req  in  1  VGA needs one byte this cycle
- vga_addr  in  ADDR_W  VGA byte address
- vga_blank  in  1  active-low blanking (0 = blanking interval)
- vga_data  out  DATA_W  returned pixel
- vga_valid  out  1  one-cycle strobe, vga_data valid
- vga_miss  out  1  one-cycle strobe, VGA request dropped by override
- cpu_req  in  1  processor access request, held until grant
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  processor address
- cpu_wdata  in  DATA_W  write data
- cpu_gnt  out  1  one-cycle strobe, access issued
- cpu_rdata  out  DATA_W  read data
- cpu_rvalid  out  1  one-cycle strobe, cpu_rdata valid
- mem_addr  out  ADDR_W  RAM address (registered)
- mem_we  out  1  RAM write enable (registered)
- mem_wdata  out  DATA_W  RAM write data (registered)
- mem_rdata  in  DATA_W  RAM read data, synchronous, 1-cycle latency
- conflict_cnt  out  16  saturating count of denied CPU cycles

## Operation
- FSM states give the owner of the current RAM slot: IDLE, VGA_RD, CPU_RD, CPU_WR. A new state is chosen every edge.
- Priority at each edge, in order:
  - wait_cnt == MAX_WAIT and CPU eligible -> CPU.
  - else vga_req -> VGA_RD.
  - else CPU eligible -> CPU_RD or CPU_WR by cpu_we.
  - else IDLE.
- CPU eligible means cpu_req = 1 and cpu_gnt = 0. The bubble after every grant lets the CPU drop or change its request.
- A CPU override while vga_req = 1 pulses vga_miss on the same edge. The VGA interface repeats its previous pixel.
- wait_cnt: increments on each edge where the CPU is eligible but not granted. Clears on grant or when the CPU is not eligible. Never exceeds MAX_WAIT.
- conflict_cnt: increments on the same condition, saturates at 16'hFFFF, and clears only on reset.
- mem_we is 1 only in CPU_WR. mem_wdata holds the last write value otherwise. mem_addr holds its value in IDLE.
- A 2-entry owner tag pipeline routes mem_rdata to vga_data/vga_valid or cpu_rdata/cpu_rvalid.
- Reset (async, any time):
  - state = IDLE.
  - All strobes, mem_we, mem_addr, mem_wdata, vga_data, cpu_rdata, conflict_cnt and wait_cnt = 0.
  - In-flight returns are discarded and not replayed.

## Timing
- Request sampled at edge k -> mem_* driven from edge k, and cpu_gnt high for cycle k..k+1 if CPU.
- RAM samples at k+1. Read data is registered at edge k+2, with vga_valid or cpu_rvalid high for that single cycle.
- A CPU write is complete at edge k+1. No cpu_rvalid is produced for writes.
- VGA throughput is 1 byte per cycle. Back-to-back CPU throughput is 1 access per 2 cycles when VGA is idle.
- Worst-case CPU wait is MAX_WAIT+1 eligible cycles.

## Configuration
- IMGARB_WR_BLANK_EN defined: CPU writes are eligible only while vga_blank = 0. CPU reads are unaffected.
  - wait_cnt and conflict_cnt count only eligible cycles.
  - Override never forces a write into active video.
- Not defined: writes are eligible at any time, and vga_blank is ignored.

## Structure
- Package img_arb_pkg holds:
  - the state enum (IDLE, VGA_RD, CPU_RD, CPU_WR);
  - the owner tag constants (TAG_NONE, TAG_VGA, TAG_CPU);
  - the default ADDR_W and DATA_W.
- Sub-module img_arb_rdpipe holds the 2-stage tag/data return pipeline and generates vga_valid/cpu_rvalid. The arbiter FSM and counters stay in the top.

## Test plan
- CPU read alone, addr 0x00010, RAM[0x00010] = 0xA5 -> cpu_gnt at edge k, cpu_rvalid with 0xA5 at edge k+2, mem_we = 0.
- VGA streaming 8 consecutive vga_req while cpu_req write 0x3C is pending -> CPU is denied throughout, vga_valid arrives 2 edges after each request, conflict_cnt = 8; the write is granted on the first free cycle.
- vga_req held high continuously, cpu_req read pending -> CPU granted on the 16th edge, vga_miss pulses once on that edge, wait_cnt returns to 0.
- With IMGARB_WR_BLANK_EN, CPU write during vga_blank = 1 with no VGA traffic -> no grant and conflict_cnt stays 0. Drive vga_blank = 0 -> grant next edge, mem_we = 1 for one cycle.
- Assert reset one cycle after a VGA read is issued -> no vga_valid; all outputs are 0 asynchronously. After release, the first request behaves normally.
- Force 70000 denied cycles -> conflict_cnt holds at 0xFFFF.
